alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, operand and result width in bits.
REQ-002 Parameter: OPCODE_WIDTH, default 6, opcode width in bits.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: dato_a  input  DATA_WIDTH  operand A; the shifted value for shifts.
REQ-006 Port: dato_b  input  DATA_WIDTH  operand B; the unsigned shift amount for shifts.
REQ-007 Port: opcode  input  OPCODE_WIDTH  operation select (MIPS R-type funct encoding).
REQ-008 Port: out  output  DATA_WIDTH  registered result.
REQ-009 Port: zero  output  1  registered; high when the result is all zeros.
REQ-010 Port: carry  output  1  registered; carry-out for ADD, borrow for SUB, 0 for all other operations.
REQ-011 Port: overflow  output  1  registered; two's-complement overflow for ADD/SUB, 0 for all other operations.
REQ-012 Port: negative  output  1  registered; equals the result MSB.

Function
REQ-013 Opcode map: 100000 ADD; 100010 SUB; 100100 AND; 100101 OR; 100110 XOR; 100111 NOR; 000011 SRA; 000010 SRL.
REQ-014 ADD: out = (A+B) mod 2^DATA_WIDTH; carry = bit DATA_WIDTH of the unsigned sum.
REQ-015 SUB: out = (A-B) mod 2^DATA_WIDTH; carry = 1 when A < B (unsigned).
REQ-016 Overflow: set when both operands of ADD (or A and ~B for SUB) share a sign that differs from the result sign.
REQ-017 AND, OR, XOR, NOR: bitwise; NOR = ~(A|B).
REQ-018 SRL: A shifted right by B, zero-filled; B >= DATA_WIDTH gives 0.
REQ-019 SRA: A shifted right by B, filled with A[MSB]; B >= DATA_WIDTH gives all bits equal to A[MSB].
REQ-020 Any unlisted opcode, including 000000: result 0, carry 0, overflow 0, zero 1.
REQ-021 Result and flags are computed combinationally and captured into registers on every rising clk edge.
REQ-022 Latency is exactly 1 cycle from input change to out; there is no enable or handshake, and throughput is one operation per cycle.
REQ-023 All four flags are computed from the same result that is registered into out in that cycle.

Reset
REQ-024 Asserting reset clears out, carry, overflow and negative to 0 and sets zero to 1, immediately and without waiting for clk.
REQ-025 While reset is high, outputs hold their reset values regardless of the inputs.
REQ-026 The first rising edge after reset deasserts loads the current operation's result.
REQ-027 Reset asserted mid-operation discards the pending result; no partial state survives.

Structure
REQ-028 Package alu_pkg holds the opcode localparams (OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL) and the default widths.
REQ-029 One sub-module, alu_core, is permitted: a purely combinational result-and-flags generator, wrapped by alu, which holds the output registers.
REQ-030 The design contains no latches; the combinational decode assigns every signal on every path.

Verification
REQ-031 A=8, B=2, clocked → ADD out 10; SUB out 6; AND out 0, zero=1; each result appears one cycle after the opcode is applied.
REQ-032 A=3, B=1 → OR 3; XOR 2; NOR 252 with negative=1.
REQ-033 A=0x83, B=1 → SRA 193 (0xC1); SRL 65 (0x41); A=0x83, B=9 → SRA 255, SRL 0.
REQ-034 ADD 200+100 → out 44, carry=1; ADD 127+1 → out 128, overflow=1; SUB 2-8 → out 250, carry=1.
REQ-035 Opcode 000000 and opcode 111111 → out 0, zero=1.
REQ-036 Assert reset between clock edges with out=10 → out=0 and zero=1 immediately; after release, the next edge loads the current result.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: default widths, MIPS funct opcodes,
// and the flag bundle passed from the core to the output registers.
package alu_pkg;

  localparam int DATA_WIDTH_DEF   = 8;
  localparam int OPCODE_WIDTH_DEF = 6;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;

  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
    logic negative;
  } alu_flags_t;

  localparam alu_flags_t FLAGS_RESET = '{
    zero:     1'b1,
    carry:    1'b0,
    overflow: 1'b0,
    negative: 1'b0
  };

endpackage

// File: rtl/alu_if.sv
// Operand/opcode inputs and registered result/flag outputs
// of the ALU, bundled for the wrapper port.
interface alu_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int OPCODE_WIDTH = 6
);

  logic [DATA_WIDTH-1:0]   dato_a;
  logic [DATA_WIDTH-1:0]   dato_b;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic [DATA_WIDTH-1:0]   out;
  logic                    zero;
  logic                    carry;
  logic                    overflow;
  logic                    negative;

  modport master (
    output dato_a,
    output dato_b,
    output opcode,
    input  out,
    input  zero,
    input  carry,
    input  overflow,
    input  negative
  );

  modport slave (
    input  dato_a,
    input  dato_b,
    input  opcode,
    output out,
    output zero,
    output carry,
    output overflow,
    output negative
  );

endinterface

// File: rtl/alu_core.sv
// Purely combinational result and flag generator; every
// output is derived from the single selected result word.
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int OPCODE_WIDTH = OPCODE_WIDTH_DEF
) (
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  output logic [DATA_WIDTH-1:0]   result,
  output alu_flags_t              flags
);

  localparam int MSB = DATA_WIDTH - 1;
  localparam logic [DATA_WIDTH:0] SHIFT_LIM =
    (DATA_WIDTH+1)'(DATA_WIDTH);

  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH:0]   diff;
  logic                  big_shift;
  logic [DATA_WIDTH-1:0] srl_res;
  logic [DATA_WIDTH-1:0] sra_res;
  logic                  carry;
  logic                  ovf;

  logic is_add;
  logic is_sub;
  logic is_and;
  logic is_or;
  logic is_xor;
  logic is_nor;
  logic is_sra;
  logic is_srl;

  assign is_add = opcode == OPCODE_WIDTH'(OP_ADD);
  assign is_sub = opcode == OPCODE_WIDTH'(OP_SUB);
  assign is_and = opcode == OPCODE_WIDTH'(OP_AND);
  assign is_or  = opcode == OPCODE_WIDTH'(OP_OR);
  assign is_xor = opcode == OPCODE_WIDTH'(OP_XOR);
  assign is_nor = opcode == OPCODE_WIDTH'(OP_NOR);
  assign is_sra = opcode == OPCODE_WIDTH'(OP_SRA);
  assign is_srl = opcode == OPCODE_WIDTH'(OP_SRL);

  // Top bit of the widened difference is the unsigned borrow.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  assign big_shift = {1'b0, b} >= SHIFT_LIM;

  assign srl_res = big_shift ? '0 : (a >> b);
  assign sra_res = big_shift ? {DATA_WIDTH{a[MSB]}}
                             : DATA_WIDTH'($signed(a) >>> b);

  always_comb begin
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    unique case (1'b1)
      is_add: begin
        result = sum[MSB:0];
        carry  = sum[DATA_WIDTH];
        ovf    = (a[MSB] == b[MSB]) &&
                 (sum[MSB] != a[MSB]);
      end
      is_sub: begin
        result = diff[MSB:0];
        carry  = diff[DATA_WIDTH];
        ovf    = (a[MSB] != b[MSB]) &&
                 (diff[MSB] != a[MSB]);
      end
      is_and: result = a & b;
      is_or:  result = a | b;
      is_xor: result = a ^ b;
      is_nor: result = ~(a | b);
      is_sra: result = sra_res;
      is_srl: result = srl_res;
      default: begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
      end
    endcase
  end

  assign flags.zero     = ~|result;
  assign flags.carry    = carry;
  assign flags.overflow = ovf;
  assign flags.negative = result[MSB];

endmodule

// File: rtl/alu.sv
// Registered ALU: one operation per cycle, result and flags
// appear one clock after the operands and opcode.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int OPCODE_WIDTH = OPCODE_WIDTH_DEF
) (
  input logic   clk,
  input logic   reset,
  alu_if.slave  bus
);

  logic [DATA_WIDTH-1:0] result;
  alu_flags_t            flags;
  logic [DATA_WIDTH-1:0] out_q;
  alu_flags_t            flags_q;

  alu_core #(
    .DATA_WIDTH   (DATA_WIDTH),
    .OPCODE_WIDTH (OPCODE_WIDTH)
  ) u_core (
    .a      (bus.dato_a),
    .b      (bus.dato_b),
    .opcode (bus.opcode),
    .result (result),
    .flags  (flags)
  );

  // Reset shows an all-zero result, so zero reads high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q   <= '0;
      flags_q <= FLAGS_RESET;
    end else begin
      out_q   <= result;
      flags_q <= flags;
    end
  end

  assign bus.out      = out_q;
  assign bus.zero     = flags_q.zero;
  assign bus.carry    = flags_q.carry;
  assign bus.overflow = flags_q.overflow;
  assign bus.negative = flags_q.negative;

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for the registered ALU with
// hand-computed results and flags.
module tb_alu;
  import alu_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  alu_if #(.DATA_WIDTH(8), .OPCODE_WIDTH(6)) bus ();

  alu #(.DATA_WIDTH(8), .OPCODE_WIDTH(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] o,
                     input logic [3:0] f);
    logic [3:0] got_f;
    got_f = {bus.zero, bus.carry, bus.overflow, bus.negative};
    checks++;
    assert (bus.out === o) else begin
      errors++;
      $error("FAIL %s out got %0d exp %0d", tag, bus.out, o);
    end
    checks++;
    assert (got_f === f) else begin
      errors++;
      $error("FAIL %s zcvn got %b exp %b", tag, got_f, f);
    end
  endtask

  task automatic run(input logic [7:0] a,
                     input logic [7:0] b,
                     input logic [5:0] op);
    @(negedge clk);
    bus.dato_a = a;
    bus.dato_b = b;
    bus.opcode = op;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.dato_a = 8'd8;
    bus.dato_b = 8'd2;
    bus.opcode = OP_ADD;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold", 8'd0, 4'b1000);

    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("first_edge_add", 8'd10, 4'b0000);

    // opcode changes at negedge; out must keep old value until edge
    @(negedge clk);
    bus.opcode = OP_SUB;
    #1;
    chk("latency_hold", 8'd10, 4'b0000);
    @(posedge clk);
    #1;
    chk("sub_8_2", 8'd6, 4'b0000);

    run(8'd8, 8'd2, OP_AND);
    chk("and_8_2", 8'd0, 4'b1000);
    run(8'd3, 8'd1, OP_OR);
    chk("or_3_1", 8'd3, 4'b0000);
    run(8'd3, 8'd1, OP_XOR);
    chk("xor_3_1", 8'd2, 4'b0000);
    run(8'd3, 8'd1, OP_NOR);
    chk("nor_3_1", 8'd252, 4'b0001);

    run(8'h83, 8'd1, OP_SRA);
    chk("sra_83_1", 8'd193, 4'b0001);
    run(8'h83, 8'd1, OP_SRL);
    chk("srl_83_1", 8'd65, 4'b0000);
    run(8'h83, 8'd9, OP_SRA);
    chk("sra_83_9", 8'd255, 4'b0001);
    run(8'h83, 8'd9, OP_SRL);
    chk("srl_83_9", 8'd0, 4'b1000);
    run(8'h83, 8'd8, OP_SRA);
    chk("sra_83_8", 8'd255, 4'b0001);
    run(8'h83, 8'd8, OP_SRL);
    chk("srl_83_8", 8'd0, 4'b1000);
    run(8'h83, 8'd7, OP_SRL);
    chk("srl_83_7", 8'd1, 4'b0000);
    run(8'h43, 8'd7, OP_SRA);
    chk("sra_43_7", 8'd0, 4'b1000);

    run(8'd200, 8'd100, OP_ADD);
    chk("add_carry", 8'd44, 4'b0100);
    run(8'd127, 8'd1, OP_ADD);
    chk("add_ovf", 8'd128, 4'b0011);
    run(8'd2, 8'd8, OP_SUB);
    chk("sub_borrow", 8'd250, 4'b0101);
    run(8'h80, 8'd1, OP_SUB);
    chk("sub_ovf", 8'h7f, 4'b0010);
    run(8'd5, 8'd5, OP_SUB);
    chk("sub_equal", 8'd0, 4'b1000);
    run(8'h80, 8'h80, OP_ADD);
    chk("add_ovf_zero", 8'd0, 4'b1110);

    run(8'd8, 8'd2, 6'b000000);
    chk("op_000000", 8'd0, 4'b1000);
    run(8'hff, 8'hff, 6'b111111);
    chk("op_111111", 8'd0, 4'b1000);

    run(8'd8, 8'd2, OP_ADD);
    chk("pre_reset_add", 8'd10, 4'b0000);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset", 8'd0, 4'b1000);
    @(posedge clk);
    #1;
    chk("reset_over_edge", 8'd0, 4'b1000);
    @(negedge clk);
    reset = 1'b0;
    bus.opcode = OP_SUB;
    @(posedge clk);
    #1;
    chk("post_reset_sub", 8'd6, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
